// File: rtl/ntt_reorder_if.sv
// Two-lane coefficient stream between the NTT output and the reorder buffer.
// The master drives bit-reversed input beats. The slave returns natural-order beats and busy.
interface ntt_reorder_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  in_en;
  logic [DATA_WIDTH-1:0] in [2];
  logic                  out_en;
  logic [DATA_WIDTH-1:0] out [2];
  logic                  busy;

  modport master (output in_en, in, input out_en, out, busy);
  modport slave  (input in_en, in, output out_en, out, busy);
endinterface

// File: rtl/ntt_reorder.sv
// Ping-pong reorder buffer that converts bit-reversed NTT output frames to natural order.
// Each frame is written into one bank while the previously completed frame is read out of the other.
module ntt_reorder #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 256
) (
  input  logic        clk,
  input  logic        rst,
  ntt_reorder_if.slave bus
);
  localparam int L    = $clog2(N);
  localparam int HALF = N / 2;
  localparam int CW   = L - 1;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] x);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = x[L-1-i];
    return r;
  endfunction

  // Bank select is the top address bit: words 0..N-1 are bank 0, N..2N-1 are bank 1.
  logic [DATA_WIDTH-1:0] mem [0:2*N-1];

  logic [CW-1:0]         wcnt_reg;
  logic                  wbank_reg;
  logic [CW-1:0]         rcnt_reg;
  logic                  rbank_reg;
  state_t                state_reg;
  logic                  out_en_reg;
  logic [DATA_WIDTH-1:0] out_reg [2];

  logic [L:0] waddr [2];
  logic [L:0] raddr [2];
  logic       wlast;
  logic       rlast;

  assign wlast = bus.in_en && (wcnt_reg == CW'(HALF - 1));
  assign rlast = (rcnt_reg == CW'(HALF - 1));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign waddr[gi]   = {wbank_reg, bitrev({wcnt_reg, 1'(gi)})};
      assign raddr[gi]   = {rbank_reg, rcnt_reg, 1'(gi)};
      assign bus.out[gi] = out_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (bus.in_en) begin
      mem[waddr[0]] <= bus.in[0];
      mem[waddr[1]] <= bus.in[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_reg   <= '0;
      wbank_reg  <= 1'b0;
      rcnt_reg   <= '0;
      rbank_reg  <= 1'b0;
      state_reg  <= IDLE;
      out_en_reg <= 1'b0;
      for (int k = 0; k < 2; k++) out_reg[k] <= '0;
    end else begin
      // A gap in in_en mid-frame discards the partial frame; the same bank is refilled.
      if (bus.in_en) begin
        wcnt_reg <= wlast ? '0 : wcnt_reg + 1'b1;
        if (wlast) wbank_reg <= ~wbank_reg;
      end else begin
        wcnt_reg <= '0;
      end

      case (state_reg)
        IDLE: begin
          if (wlast) begin
            state_reg <= READ;
            rbank_reg <= wbank_reg;
            rcnt_reg  <= '0;
          end
        end
        READ: begin
          if (wlast) begin
            rbank_reg <= wbank_reg;
            rcnt_reg  <= '0;
          end else if (rlast) begin
            state_reg <= IDLE;
            rcnt_reg  <= '0;
          end else begin
            rcnt_reg <= rcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      out_en_reg <= (state_reg == READ);
      if (state_reg == READ) begin
        for (int k = 0; k < 2; k++) out_reg[k] <= mem[raddr[k]];
      end
    end
  end

  assign bus.out_en = out_en_reg;
  assign bus.busy   = (wcnt_reg != '0) | (state_reg == READ) | out_en_reg;
endmodule
